// File: rtl/ball_physics.sv
// Per-frame ball motion engine: gravity, wall/ceiling/net bounces, player hits
// and ground-touch scoring in 640x480 game space, updated once per accepted frame tick.
module ball_physics #(
  parameter int FIELD_W      = 640,
  parameter int BALL_SIZE    = 80,
  parameter int GROUND_Y     = 400,
  parameter int NET_LX       = 314,
  parameter int NET_RX       = 326,
  parameter int NET_TOP      = 300,
  parameter int GRAVITY      = 1,
  parameter int MAX_VY       = 15,
  parameter int HIT_VX       = 6,
  parameter int HIT_VY       = 14,
  parameter int HIT_COOLDOWN = 8,
  parameter int SERVE_FRAMES = 60,
  parameter int DEAD_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       freeze,
  input  logic       player_cover,
  input  logic       COM_cover,
  input  logic [9:0] p1_x,
  input  logic [9:0] p2_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       point_valid,
  output logic       point_p1,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, FLY = 2'd2, DEAD = 2'd3} state_e;
  typedef logic signed [11:0] s12_t;

  localparam s12_t       X_MAX       = s12_t'(FIELD_W - BALL_SIZE);
  localparam s12_t       BALL        = s12_t'(BALL_SIZE);
  localparam s12_t       HALF_BALL   = s12_t'(BALL_SIZE / 2);
  localparam s12_t       HALF_PLAYER = 12'sd64;
  localparam s12_t       GROUND      = s12_t'(GROUND_Y);
  localparam s12_t       NET_L       = s12_t'(NET_LX);
  localparam s12_t       NET_R       = s12_t'(NET_RX);
  localparam s12_t       NET_T       = s12_t'(NET_TOP);
  localparam s12_t       GRAV        = s12_t'(GRAVITY);
  localparam s12_t       VY_MAX      = s12_t'(MAX_VY);
  localparam s12_t       VX_HIT      = s12_t'(HIT_VX);
  localparam s12_t       VY_HIT      = s12_t'(HIT_VY);
  localparam logic [9:0] X_MAX_U     = 10'(FIELD_W - BALL_SIZE);
  localparam logic [9:0] GROUND_U    = 10'(GROUND_Y);
  localparam logic [9:0] NET_REST_U  = 10'(NET_TOP - BALL_SIZE);
  localparam logic [9:0] X_SERVE_P1  = 10'd100;
  localparam logic [9:0] X_SERVE_P2  = 10'(FIELD_W - BALL_SIZE - 100);
  localparam logic [9:0] Y_SERVE     = 10'd40;
  localparam logic [9:0] X_SCORE_P1  = 10'(FIELD_W / 2 - BALL_SIZE / 2);
  localparam logic [3:0] COOLDOWN    = 4'(HIT_COOLDOWN);
  localparam logic [6:0] T_SERVE     = 7'(SERVE_FRAMES);
  localparam logic [6:0] T_DEAD      = 7'(DEAD_FRAMES);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  s12_t       vx_q, vx_d, vy_q, vy_d;
  logic [3:0] cooldown_q, cooldown_d;
  logic [6:0] timer_q, timer_d;
  logic       serve_p1_q, serve_p1_d;
  logic       point_valid_q, point_valid_d;
  logic       point_p1_q, point_p1_d;

  s12_t       xs, ys, ball_cx, player_cx, vy_grav, vx_n, vy_n, nx, ny;
  logic [9:0] x_n, y_n;
  logic       hit, grounded, scored_p1, enter_serve;

  always_comb begin
    // NOTE: every variable is given a default first so no path can infer a latch.
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    vx_d          = vx_q;
    vy_d          = vy_q;
    cooldown_d    = cooldown_q;
    timer_d       = timer_q;
    serve_p1_d    = serve_p1_q;
    point_valid_d = 1'b0;
    point_p1_d    = point_p1_q;
    enter_serve   = 1'b0;

    // One flight step: hit or gravity, move, then walls, ceiling, net, ground.
    xs        = $signed({2'b00, x_q});
    ys        = $signed({2'b00, y_q});
    ball_cx   = xs + HALF_BALL;
    player_cx = $signed({2'b00, player_cover ? p1_x : p2_x}) + HALF_PLAYER;
    hit       = (cooldown_q == 4'd0) && (player_cover || COM_cover);
    vy_grav   = (vy_q + GRAV > VY_MAX) ? VY_MAX : vy_q + GRAV;
    vx_n      = hit ? ((ball_cx < player_cx) ? -VX_HIT : VX_HIT) : vx_q;
    vy_n      = hit ? -VY_HIT : vy_grav;
    nx        = xs + vx_n;
    ny        = ys + vy_n;
    x_n       = nx[9:0];
    y_n       = ny[9:0];

    if (nx < 0) begin
      x_n  = '0;
      vx_n = -vx_n;
    end else if (nx > X_MAX) begin
      x_n  = X_MAX_U;
      vx_n = -vx_n;
    end
    if (ny < 0) begin
      y_n  = '0;
      vy_n = -vy_n;
    end
    if ((nx + BALL > NET_L) && (nx < NET_R) && (ny + BALL > NET_T)) begin
      if (ys + BALL <= NET_T) begin
        y_n  = NET_REST_U;
        vy_n = -vy_n;
      end else begin
        x_n  = x_q;
        vx_n = -vx_n;
      end
    end
    grounded = (ny >= GROUND);
    if (grounded) begin
      y_n  = GROUND_U;
      vx_n = '0;
      vy_n = '0;
    end
    scored_p1 = (x_n >= X_SCORE_P1);

    if (!run) begin
      state_d    = IDLE;
      x_d        = X_SERVE_P1;
      y_d        = Y_SERVE;
      vx_d       = '0;
      vy_d       = '0;
      cooldown_d = '0;
      timer_d    = '0;
      serve_p1_d = 1'b1;
      point_p1_d = 1'b0;
    end else if (frame_tick && !freeze) begin
      unique case (state_q)
        IDLE:  enter_serve = 1'b1;
        SERVE: begin
          if (timer_q <= 7'd1) begin
            state_d = FLY;
            vx_d    = '0;
            vy_d    = '0;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end
        FLY: begin
          x_d        = x_n;
          y_d        = y_n;
          vx_d       = vx_n;
          vy_d       = vy_n;
          cooldown_d = hit ? COOLDOWN : ((cooldown_q != 4'd0) ? cooldown_q - 4'd1 : 4'd0);
          if (grounded) begin
            state_d       = DEAD;
            point_valid_d = 1'b1;
            point_p1_d    = scored_p1;
            serve_p1_d    = scored_p1;
            timer_d       = T_DEAD;
          end
        end
        DEAD: begin
          if (timer_q <= 7'd1) enter_serve = 1'b1;
          else                 timer_d     = timer_q - 7'd1;
        end
        default: ;
      endcase
      if (enter_serve) begin
        state_d = SERVE;
        x_d     = serve_p1_q ? X_SERVE_P1 : X_SERVE_P2;
        y_d     = Y_SERVE;
        timer_d = T_SERVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= X_SERVE_P1;
      y_q           <= Y_SERVE;
      vx_q          <= '0;
      vy_q          <= '0;
      cooldown_q    <= '0;
      timer_q       <= '0;
      serve_p1_q    <= 1'b1;
      point_valid_q <= 1'b0;
      point_p1_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      cooldown_q    <= cooldown_d;
      timer_q       <= timer_d;
      serve_p1_q    <= serve_p1_d;
      point_valid_q <= point_valid_d;
      point_p1_q    <= point_p1_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign point_valid = point_valid_q;
  assign point_p1    = point_p1_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: serve timing, gravity, scoring, bounces,
// player hits with cooldown, freeze, run drop and reset, all with hand-computed trajectories.
module tb_ball_physics;

  logic       clk = 1'b0;
  logic       reset, frame_tick, run, freeze, player_cover, COM_cover;
  logic [9:0] p1_x, p2_x, ball_x, ball_y;
  logic       point_valid, point_p1;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ball_physics dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .run          (run),
    .freeze       (freeze),
    .player_cover (player_cover),
    .COM_cover    (COM_cover),
    .p1_x         (p1_x),
    .p2_x         (p2_x),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .point_valid  (point_valid),
    .point_p1     (point_p1),
    .state        (state)
  );

  // One accepted frame: pulse frame_tick across a rising edge, return on the following falling edge.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; freeze = 1'b0; frame_tick = 1'b0;
    player_cover = 1'b0; COM_cover = 1'b0; p1_x = 10'd100; p2_x = 10'd400;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, ball_x, ball_y, point_valid} !== {2'd0, 10'd100, 10'd40, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got st=%0d x=%0d y=%0d pv=%0d expected st=0 x=100 y=40 pv=0",
               state, ball_x, ball_y, point_valid);
    end
  endtask

  task automatic test_serve();
    int ey [3];
    ey = '{41, 43, 46};
    run = 1'b1;
    ticks(60);
    checks++;
    if ({state, ball_x, ball_y} !== {2'd1, 10'd100, 10'd40}) begin
      failures++;
      $display("FAIL serve_hold: got st=%0d x=%0d y=%0d expected st=1 x=100 y=40", state, ball_x, ball_y);
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {2'd2, 10'd100, 10'd40}) begin
      failures++;
      $display("FAIL serve_release: got st=%0d x=%0d y=%0d expected st=2 x=100 y=40", state, ball_x, ball_y);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({ball_x, ball_y} !== {10'd100, 10'(ey[k])}) begin
        failures++;
        $display("FAIL gravity_step%0d: got x=%0d y=%0d expected x=100 y=%0d", k + 1, ball_x, ball_y, ey[k]);
      end
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({state, ball_x, ball_y, point_valid} !== {2'd2, 10'd100, 10'd46, 1'b0}) begin
        failures++;
        $display("FAIL freeze_hold%0d: got st=%0d x=%0d y=%0d pv=%0d expected st=2 x=100 y=46 pv=0",
                 i, state, ball_x, ball_y, point_valid);
      end
    end
    freeze = 1'b0;
    tick();
    checks++;
    if (ball_y !== 10'd50) begin
      failures++;
      $display("FAIL freeze_resume: got y=%0d expected y=50", ball_y);
    end
  endtask

  task automatic test_free_fall_score();
    int ey;
    for (int k = 5; k <= 30; k++) begin
      tick();
      ey = (k <= 15) ? 40 + k * (k + 1) / 2 : 160 + 15 * (k - 15);
      checks++;
      if ({ball_x, ball_y, point_valid} !== {10'd100, 10'(ey), 1'b0}) begin
        failures++;
        $display("FAIL fall_k%0d: got x=%0d y=%0d pv=%0d expected x=100 y=%0d pv=0", k, ball_x, ball_y, point_valid, ey);
      end
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y, point_valid, point_p1} !== {2'd3, 10'd100, 10'd400, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ground_p2: got st=%0d x=%0d y=%0d pv=%0d p1=%0d expected st=3 x=100 y=400 pv=1 p1=0",
               state, ball_x, ball_y, point_valid, point_p1);
    end
    @(negedge clk);
    checks++;
    if (point_valid !== 1'b0) begin
      failures++;
      $display("FAIL point_pulse_width: got pv=%0d expected 0", point_valid);
    end
    // 89 accepted DEAD ticks with a frozen interlude in the middle.
    for (int i = 0; i < 99; i++) begin
      freeze = (i >= 45 && i < 55);
      tick();
      checks++;
      if ({state, ball_y, point_valid} !== {2'd3, 10'd400, 1'b0}) begin
        failures++;
        $display("FAIL dead_hold%0d: got st=%0d y=%0d pv=%0d expected st=3 y=400 pv=0", i, state, ball_y, point_valid);
      end
    end
    freeze = 1'b0;
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {2'd1, 10'd460, 10'd40}) begin
      failures++;
      $display("FAIL serve_p2: got st=%0d x=%0d y=%0d expected st=1 x=460 y=40", state, ball_x, ball_y);
    end
    ticks(59);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL serve_p2_hold: got st=%0d expected 1", state);
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {2'd2, 10'd460, 10'd40}) begin
      failures++;
      $display("FAIL serve_p2_fly: got st=%0d x=%0d y=%0d expected st=2 x=460 y=40", state, ball_x, ball_y);
    end
  endtask

  task automatic test_right_wall();
    int ex [17];
    int ey [17];
    ex = '{472, 478, 484, 490, 496, 502, 508, 514, 520, 526, 532, 538, 544, 550, 556, 560, 554};
    ey = '{ 13,   1,   0,  12,  25,  39,  54,  69,  84,  99, 114, 129, 144, 159, 174, 189, 204};
    p2_x = 10'd400;
    COM_cover = 1'b1;
    tick();
    COM_cover = 1'b0;
    checks++;
    if ({ball_x, ball_y} !== {10'd466, 10'd26}) begin
      failures++;
      $display("FAIL com_hit: got x=%0d y=%0d expected x=466 y=26", ball_x, ball_y);
    end
    for (int t = 0; t < 17; t++) begin
      tick();
      checks++;
      if ({ball_x, ball_y} !== {10'(ex[t]), 10'(ey[t])}) begin
        failures++;
        $display("FAIL rwall_t%0d: got x=%0d y=%0d expected x=%0d y=%0d", t + 1, ball_x, ball_y, ex[t], ey[t]);
      end
    end
    for (int t = 18; t <= 30; t++) begin
      tick();
      checks++;
      if ({ball_x, ball_y, point_valid} !== {10'(554 - 6 * (t - 17)), 10'(204 + 15 * (t - 17)), 1'b0}) begin
        failures++;
        $display("FAIL rwall_t%0d: got x=%0d y=%0d pv=%0d expected x=%0d y=%0d pv=0",
                 t, ball_x, ball_y, point_valid, 554 - 6 * (t - 17), 204 + 15 * (t - 17));
      end
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y, point_valid, point_p1} !== {2'd3, 10'd470, 10'd400, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ground_p1: got st=%0d x=%0d y=%0d pv=%0d p1=%0d expected st=3 x=470 y=400 pv=1 p1=1",
               state, ball_x, ball_y, point_valid, point_p1);
    end
    ticks(90);
    checks++;
    if ({state, ball_x, ball_y} !== {2'd1, 10'd100, 10'd40}) begin
      failures++;
      $display("FAIL serve_p1_after_point: got st=%0d x=%0d y=%0d expected st=1 x=100 y=40", state, ball_x, ball_y);
    end
    ticks(60);
  endtask

  task automatic test_net_top();
    int ey [23];
    ey = '{268, 256, 245, 235, 226, 218, 211, 205, 200, 196, 193, 191,
           190, 190, 191, 193, 196, 200, 205, 211, 218, 220, 213};
    ticks(24);
    checks++;
    if ({state, ball_x, ball_y} !== {2'd2, 10'd100, 10'd295}) begin
      failures++;
      $display("FAIL net_setup: got st=%0d x=%0d y=%0d expected st=2 x=100 y=295", state, ball_x, ball_y);
    end
    p1_x = 10'd0;
    player_cover = 1'b1;
    tick();
    player_cover = 1'b0;
    checks++;
    if ({ball_x, ball_y} !== {10'd106, 10'd281}) begin
      failures++;
      $display("FAIL net_hit: got x=%0d y=%0d expected x=106 y=281", ball_x, ball_y);
    end
    for (int m = 0; m < 23; m++) begin
      tick();
      checks++;
      if ({ball_x, ball_y} !== {10'(112 + 6 * m), 10'(ey[m])}) begin
        failures++;
        $display("FAIL net_m%0d: got x=%0d y=%0d expected x=%0d y=%0d", m + 1, ball_x, ball_y, 112 + 6 * m, ey[m]);
      end
    end
  endtask

  task automatic test_run_drop();
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, ball_x, ball_y, point_valid} !== {2'd0, 10'd100, 10'd40, 1'b0}) begin
      failures++;
      $display("FAIL run_drop: got st=%0d x=%0d y=%0d pv=%0d expected st=0 x=100 y=40 pv=0",
               state, ball_x, ball_y, point_valid);
    end
    run = 1'b1;
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {2'd1, 10'd100, 10'd40}) begin
      failures++;
      $display("FAIL rerun_serve: got st=%0d x=%0d y=%0d expected st=1 x=100 y=40", state, ball_x, ball_y);
    end
    ticks(60);
  endtask

  task automatic test_hit_cooldown();
    int ex [18];
    int ey [18];
    ex = '{94, 88, 82, 76, 70, 64, 58, 52, 46, 40, 34, 28, 22, 16, 10, 4, 0,  6};
    ey = '{26, 13,  1,  0, 12, 25, 39, 54, 69, 55, 42, 30, 19,  9,  0, 0, 9, 19};
    p1_x = 10'd100;
    p2_x = 10'd0;
    for (int t = 0; t < 18; t++) begin
      player_cover = (t < 10);
      COM_cover    = (t == 9);
      tick();
      checks++;
      if ({ball_x, ball_y} !== {10'(ex[t]), 10'(ey[t])}) begin
        failures++;
        $display("FAIL hit_t%0d: got x=%0d y=%0d expected x=%0d y=%0d", t + 1, ball_x, ball_y, ex[t], ey[t]);
      end
    end
    player_cover = 1'b0;
    COM_cover    = 1'b0;
  endtask

  task automatic test_reset_in_dead();
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    ticks(61 + 31);
    checks++;
    if ({state, ball_y} !== {2'd3, 10'd400}) begin
      failures++;
      $display("FAIL dead_setup: got st=%0d y=%0d expected st=3 y=400", state, ball_y);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({state, ball_x, ball_y, point_valid} !== {2'd0, 10'd100, 10'd40, 1'b0}) begin
      failures++;
      $display("FAIL reset_dead: got st=%0d x=%0d y=%0d pv=%0d expected st=0 x=100 y=40 pv=0",
               state, ball_x, ball_y, point_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_serve();
    test_freeze();
    test_free_fall_score();
    test_right_wall();
    test_net_top();
    test_run_drop();
    test_hit_cooldown();
    test_reset_in_dead();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
